// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle IF/ID/EXE/MEM/WB control sequencer with stalls, single-step and retire count
module mc_ctrl_fsm #(
  parameter int CNT_W = 16,
  parameter bit STEP_MODE = 1'b0
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             step,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             imem_rdy,
  input  logic             dmem_ack,
  output logic [2:0]       state,
  output logic             IRWre,
  output logic             PCWre,
  output logic [1:0]       PCSrc,
  output logic [2:0]       ALUOp,
  output logic             ALUSrcB,
  output logic             ExtSel,
  output logic             RegDst,
  output logic             RegWre,
  output logic             DBDataSrc,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             illegal,
  output logic             halted,
  output logic [CNT_W-1:0] instr_cnt
);
  typedef enum logic [2:0] {
    S_IF = 3'b000, S_ID = 3'b001, S_EXE = 3'b010, S_MEM = 3'b011, S_WB = 3'b100, S_HALT = 3'b101
  } state_t;
  typedef enum logic [3:0] {K_R, K_ADDI, K_ORI, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_HALT, K_ILL} kind_t;

  function automatic kind_t decode(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b000000: decode = (fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 || fn == 6'b100101) ? K_R : K_ILL;
      6'b001000: decode = K_ADDI;
      6'b001101: decode = K_ORI;
      6'b100011: decode = K_LW;
      6'b101011: decode = K_SW;
      6'b000100: decode = K_BEQ;
      6'b000101: decode = K_BNE;
      6'b000010: decode = K_J;
      6'b111111: decode = K_HALT;
      default:   decode = K_ILL;
    endcase
  endfunction

  state_t     st, nxt;
  kind_t      kid, kq;
  logic [5:0] fn_q;
  logic       retire, set_ill, br;

  assign kid    = decode(opcode, funct);
  assign state  = st;
  assign halted = st == S_HALT;
  assign br     = kq == K_BEQ || kq == K_BNE;

  // Next-state and Moore control decode from state plus the latched instruction
  always_comb begin
    nxt = st;
    IRWre = 1'b0;
    PCWre = 1'b0;
    PCSrc = 2'b11;
    ALUOp = 3'b000;
    ALUSrcB = 1'b0;
    ExtSel = 1'b0;
    RegDst = 1'b0;
    RegWre = 1'b0;
    DBDataSrc = 1'b0;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    retire = 1'b0;
    set_ill = 1'b0;
    case (st)
      S_IF: begin
        IRWre = imem_rdy && (!STEP_MODE || step);
        nxt = IRWre ? S_ID : S_IF;
      end
      S_ID: begin
        PCWre = kid == K_J;
        PCSrc = PCWre ? 2'b10 : 2'b11;
        retire = PCWre;
        set_ill = kid == K_ILL;
        nxt = PCWre ? S_IF : (kid == K_HALT || set_ill) ? S_HALT : S_EXE;
      end
      S_EXE: begin
        ALUOp = kq == K_R ? (fn_q == 6'b100010 ? 3'b001 : fn_q == 6'b100100 ? 3'b010 :
                             fn_q == 6'b100101 ? 3'b011 : 3'b000) :
                kq == K_ORI ? 3'b011 : br ? 3'b001 : 3'b000;
        ALUSrcB = kq inside {K_ADDI, K_ORI, K_LW, K_SW};
        ExtSel = kq != K_ORI && kq != K_R;
        PCWre = br;
        PCSrc = br ? {1'b0, kq == K_BEQ ? zero : !zero} : 2'b11;
        retire = br;
        nxt = br ? S_IF : (kq == K_LW || kq == K_SW) ? S_MEM : S_WB;
      end
      S_MEM: begin
        mem_rd = kq == K_LW;
        mem_wr = kq == K_SW;
        PCWre = dmem_ack && mem_wr;
        PCSrc = PCWre ? 2'b00 : 2'b11;
        retire = PCWre;
        nxt = !dmem_ack ? S_MEM : mem_wr ? S_IF : S_WB;
      end
      S_WB: begin
        RegWre = 1'b1;
        RegDst = kq == K_R;
        DBDataSrc = kq == K_LW;
        PCWre = 1'b1;
        PCSrc = 2'b00;
        retire = 1'b1;
        nxt = S_IF;
      end
      S_HALT: nxt = S_HALT;
      default: nxt = S_IF;
    endcase
  end

  // State register, saturating retire counter and sticky illegal flag
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      st <= S_IF;
      instr_cnt <= '0;
      illegal <= 1'b0;
    end else begin
      st <= nxt;
      if (retire && !(&instr_cnt)) instr_cnt <= instr_cnt + 1'b1;
      if (set_ill) illegal <= 1'b1;
    end
  end

  // Hold the decoded instruction for the EXE/MEM/WB cycles
  always_ff @(posedge CLK) begin
    if (st == S_ID) begin
      kq <= kid;
      fn_q <= funct;
    end
  end
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: table-driven check of the sequencer plus single-step and counter saturation sequences
module tb_mc_ctrl_fsm;
  localparam logic [5:0] OR = 6'b000000, LW = 6'b100011, SW = 6'b101011, ADDI = 6'b001000;
  localparam logic [5:0] ORI = 6'b001101, BEQ = 6'b000100, BNE = 6'b000101, J = 6'b000010, HLT = 6'b111111;
  localparam logic [5:0] FADD = 6'b100000, FSUB = 6'b100010, BAD = 6'b010101;

  logic CLK = 1'b0, Reset, step0, step1, zero, imem_rdy, dmem_ack;
  logic [5:0] opcode, funct;
  logic [2:0] st0, st1, aop0, aop1;
  logic [1:0] pcs0, pcs1, cnt1;
  logic [15:0] cnt0;
  logic irw0, pcw0, sb0, ex0, rdst0, rw0, dbs0, mr0, mw0, ill0, hlt0;
  logic irw1, pcw1, sb1, ex1, rdst1, rw1, dbs1, mr1, mw1, ill1, hlt1;
  int n = 0, nfail = 0;

  typedef struct {
    logic r;
    logic [5:0] op;
    logic [5:0] fn;
    logic z, ir, da;
    logic [34:0] x;
  } vec_t;
  vec_t vq[$];

  always #5 CLK = ~CLK;

  mc_ctrl_fsm u0 (
    .CLK(CLK), .Reset(Reset), .step(step0), .opcode(opcode), .funct(funct), .zero(zero),
    .imem_rdy(imem_rdy), .dmem_ack(dmem_ack), .state(st0), .IRWre(irw0), .PCWre(pcw0), .PCSrc(pcs0),
    .ALUOp(aop0), .ALUSrcB(sb0), .ExtSel(ex0), .RegDst(rdst0), .RegWre(rw0), .DBDataSrc(dbs0),
    .mem_rd(mr0), .mem_wr(mw0), .illegal(ill0), .halted(hlt0), .instr_cnt(cnt0)
  );

  mc_ctrl_fsm #(.CNT_W(2), .STEP_MODE(1'b1)) u1 (
    .CLK(CLK), .Reset(Reset), .step(step1), .opcode(opcode), .funct(funct), .zero(zero),
    .imem_rdy(imem_rdy), .dmem_ack(dmem_ack), .state(st1), .IRWre(irw1), .PCWre(pcw1), .PCSrc(pcs1),
    .ALUOp(aop1), .ALUSrcB(sb1), .ExtSel(ex1), .RegDst(rdst1), .RegWre(rw1), .DBDataSrc(dbs1),
    .mem_rd(mr1), .mem_wr(mw1), .illegal(ill1), .halted(hlt1), .instr_cnt(cnt1)
  );

  function automatic logic [34:0] e(input int s, irw, pcw, pcs, aop, sb, ex, rdst, rw, dbs, mr, mw, ill, hlt, cnt);
    return {3'(s), 1'(irw), 1'(pcw), 2'(pcs), 3'(aop), 1'(sb), 1'(ex), 1'(rdst), 1'(rw), 1'(dbs),
            1'(mr), 1'(mw), 1'(ill), 1'(hlt), 16'(cnt)};
  endfunction
  function automatic logic [34:0] fi(input int irw, cnt);
    return e(0, irw, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, cnt);
  endfunction
  function automatic logic [34:0] fd(input int cnt);
    return e(1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, cnt);
  endfunction
  function automatic logic [34:0] fh(input int ill, cnt);
    return e(5, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, ill, 1, cnt);
  endfunction

  task automatic add(input logic r, input logic [5:0] op, input logic [5:0] fn, input logic z,
                     input logic ir, input logic da, input logic [34:0] x);
    vq.push_back('{r, op, fn, z, ir, da, x});
  endtask

  task automatic chk(input string nm, input logic [34:0] a, input logic [34:0] x);
    n++;
    if (a !== x) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, a, x);
    end
  endtask

  task automatic fill();
    add(1, OR, FADD, 0, 1, 0, fi(1, 0));
    add(1, OR, FADD, 0, 1, 0, fd(0));
    add(1, OR, FADD, 0, 1, 0, e(2, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(1, OR, FADD, 0, 1, 0, e(4, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    add(1, LW, 0, 0, 1, 0, fi(1, 1));
    add(1, LW, 0, 0, 1, 0, fd(1));
    add(1, LW, 0, 0, 1, 0, e(2, 0, 0, 3, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1));
    for (int i = 0; i < 3; i++) add(1, LW, 0, 0, 1, 0, e(3, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
    add(1, LW, 0, 0, 1, 1, e(3, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
    add(1, LW, 0, 0, 1, 0, e(4, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1));
    add(1, SW, 0, 0, 0, 0, fi(0, 2));
    add(1, SW, 0, 0, 0, 0, fi(0, 2));
    add(1, SW, 0, 0, 1, 0, fi(1, 2));
    add(1, SW, 0, 0, 1, 0, fd(2));
    add(1, SW, 0, 0, 1, 0, e(2, 0, 0, 3, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2));
    add(1, SW, 0, 0, 1, 1, e(3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2));
    add(1, OR, FSUB, 0, 1, 0, fi(1, 3));
    add(1, OR, FSUB, 0, 1, 0, fd(3));
    add(1, OR, FSUB, 0, 1, 0, e(2, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3));
    add(1, OR, FSUB, 0, 1, 0, e(4, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 3));
    add(1, ORI, 0, 0, 1, 0, fi(1, 4));
    add(1, ORI, 0, 0, 1, 0, fd(4));
    add(1, ORI, 0, 0, 1, 0, e(2, 0, 0, 3, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4));
    add(1, ORI, 0, 0, 1, 0, e(4, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 4));
    add(1, BEQ, 0, 1, 1, 0, fi(1, 5));
    add(1, BEQ, 0, 1, 1, 0, fd(5));
    add(1, BEQ, 0, 1, 1, 0, e(2, 0, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 5));
    add(1, BEQ, 0, 0, 1, 0, fi(1, 6));
    add(1, BEQ, 0, 0, 1, 0, fd(6));
    add(1, BEQ, 0, 0, 1, 0, e(2, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 6));
    add(1, BNE, 0, 0, 1, 0, fi(1, 7));
    add(1, BNE, 0, 0, 1, 0, fd(7));
    add(1, BNE, 0, 0, 1, 0, e(2, 0, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 7));
    add(1, BNE, 0, 1, 1, 0, fi(1, 8));
    add(1, BNE, 0, 1, 1, 0, fd(8));
    add(1, BNE, 0, 1, 1, 0, e(2, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 8));
    add(1, J, 0, 0, 1, 0, fi(1, 9));
    add(1, J, 0, 0, 1, 0, e(1, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9));
    add(1, HLT, 0, 0, 1, 0, fi(1, 10));
    add(1, HLT, 0, 0, 1, 0, fd(10));
    for (int i = 0; i < 20; i++) add(1, HLT, 0, 0, 1, 1, fh(0, 10));
    add(0, BAD, 0, 0, 1, 0, fh(0, 10));
    add(1, BAD, 0, 0, 1, 0, fi(1, 0));
    add(1, BAD, 0, 0, 1, 0, fd(0));
    add(1, BAD, 0, 0, 1, 0, fh(1, 0));
    add(1, BAD, 0, 0, 1, 0, fh(1, 0));
    add(0, BAD, 0, 0, 1, 0, fh(1, 0));
    add(1, OR, 0, 0, 0, 0, fi(0, 0));
    add(1, OR, 0, 0, 1, 0, fi(1, 0));
    add(1, OR, 0, 0, 1, 0, fd(0));
    add(1, OR, 0, 0, 1, 0, fh(1, 0));
    add(0, OR, FADD, 0, 1, 0, fh(1, 0));
    add(1, OR, FADD, 0, 1, 0, fi(1, 0));
    add(1, OR, FADD, 0, 1, 0, fd(0));
    add(1, OR, FADD, 0, 1, 0, e(2, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(0, OR, FADD, 0, 1, 0, e(4, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    add(1, ADDI, 0, 0, 0, 0, fi(0, 0));
    add(1, ADDI, 0, 0, 1, 0, fi(1, 0));
    add(1, ADDI, 0, 0, 1, 0, fd(0));
    add(1, ADDI, 0, 0, 1, 0, e(2, 0, 0, 3, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    add(1, ADDI, 0, 0, 1, 0, e(4, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    add(1, OR, FADD, 0, 0, 0, fi(0, 1));
  endtask

  initial begin
    fill();
    Reset = 1'b0; step0 = 1'b0; step1 = 1'b0; zero = 1'b0; imem_rdy = 1'b0; dmem_ack = 1'b0;
    opcode = OR; funct = FADD;
    repeat (2) @(negedge CLK);
    foreach (vq[i]) begin
      @(negedge CLK);
      Reset = vq[i].r; opcode = vq[i].op; funct = vq[i].fn; zero = vq[i].z;
      imem_rdy = vq[i].ir; dmem_ack = vq[i].da;
      #1;
      chk($sformatf("vec%0d", i),
          {st0, irw0, pcw0, pcs0, aop0, sb0, ex0, rdst0, rw0, dbs0, mr0, mw0, ill0, hlt0, cnt0}, vq[i].x);
    end
    opcode = OR; funct = FADD; imem_rdy = 1'b1; dmem_ack = 1'b0; Reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      #1 chk("step_idle", 35'({st1, irw1, cnt1}), 35'({3'd0, 1'b0, 2'd0}));
    end
    for (int k = 1; k <= 5; k++) begin
      @(negedge CLK);
      step1 = 1'b1;
      #1 chk("step_irwre", 35'({st1, irw1}), 35'({3'd0, 1'b1}));
      @(negedge CLK);
      step1 = 1'b0;
      repeat (3) @(negedge CLK);
      #1 chk("step_cnt", 35'({st1, irw1, cnt1}), 35'({3'd0, 1'b0, 2'(k > 3 ? 3 : k)}));
      repeat (2) @(negedge CLK);
      #1 chk("step_hold", 35'({st1, cnt1}), 35'({3'd0, 2'(k > 3 ? 3 : k)}));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n, nfail);
    $finish;
  end
endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Multi-cycle control sequencer for the CPU datapath. Walks each instruction through fetch, decode, execute, memory and write-back. Produces the per-cycle enables for the instruction register, ALU, register file and data memory. Produces the one-cycle PC-advance strobe and PC source select that drive the PC adder's nextIns and PCSrc inputs. Stalls on instruction and data memory handshakes, supports single-step, and counts retired instructions.

Parameters:
CNT_W, 16, width of retired-instruction counter (saturating)
STEP_MODE, 0, 1 = pause in IF until step pulse each instruction; 0 = free run

Ports:
CLK  in  1  clock, all state on rising edge
Reset  in  1  reset, synchronous, active-low
step  in  1  single-step request, sampled only when STEP_MODE=1
opcode  in  6  instruction [31:26], from IR
funct  in  6  instruction [5:0], from IR
zero  in  1  ALU zero flag, valid in EXE
imem_rdy  in  1  instruction memory data valid
dmem_ack  in  1  data memory access complete
state  out  3  current state: IF=000 ID=001 EXE=010 MEM=011 WB=100 HALT=101
IRWre  out  1  load instruction register
PCWre  out  1  one-cycle PC-advance strobe (to nextIns)
PCSrc  out  2  00 PC+4, 01 branch, 10 jump, 11 hold
ALUOp  out  3  000 add, 001 sub, 010 and, 011 or
ALUSrcB  out  1  0 = rt, 1 = extended immediate
ExtSel  out  1  0 = zero-extend, 1 = sign-extend
RegDst  out  1  0 = rt, 1 = rd
RegWre  out  1  register file write enable
DBDataSrc  out  1  0 = ALU result, 1 = memory data
mem_rd  out  1  data memory read request
mem_wr  out  1  data memory write request
illegal  out  1  sticky, unsupported opcode/funct seen
halted  out  1  high in HALT
instr_cnt  out  CNT_W  retired instructions, saturates at all-ones

Behaviour:
- Reset=0 at rising edge: state=IF, instr_cnt=0, illegal=0. All strobes/enables 0, PCSrc=11. Applies mid-instruction; nothing is committed.
- Decode set: R-type op 000000 with funct 100000 add, 100010 sub, 100100 and, 100101 or. addi 001000 (sign-ext), ori 001101 (zero-ext). lw 100011, sw 101011, beq 000100, bne 000101, j 000010, halt 111111.
- IF: hold while imem_rdy=0, or while STEP_MODE=1 and step=0. Otherwise IRWre=1 for exactly that cycle, then go to ID.
- ID: j -> PCWre=1, PCSrc=10, retire, go to IF. halt -> go to HALT, no retire. Illegal -> set illegal, go to HALT. All others -> EXE.
- EXE: ALUOp/ALUSrcB/ExtSel driven for decoded op.
  - beq/bne use ALUOp=001, ALUSrcB=0. Taken (beq&zero or bne&!zero) -> PCSrc=01, else PCSrc=00. PCWre=1, retire, go to IF.
  - lw/sw -> MEM. R-type/addi/ori -> WB.
- MEM: lw -> mem_rd=1. sw -> mem_wr=1. Request held until dmem_ack=1.
  - On the ack cycle: sw -> PCWre=1, PCSrc=00, retire, go to IF. lw -> WB.
- WB: RegWre=1. RegDst=1 for R-type only. DBDataSrc=1 for lw only. PCWre=1, PCSrc=00, retire, go to IF.
- HALT: absorbing until reset. PCWre=0, PCSrc=11, halted=1.
- PCWre is never high two consecutive cycles. PCSrc=11 whenever PCWre=0.
- Retire = instr_cnt+1, saturating at 2^CNT_W-1.
- Latency in cycles, zero wait states: j 2, beq/bne 3, sw 4, R/addi/ori 4, lw 5. Each imem/dmem wait cycle adds 1.
- Outputs are Moore decodes of state plus latched opcode/funct. Only PCSrc in EXE depends on the live zero input.

Test Plan:
- Reset, imem_rdy=1, R-type add -> states IF,ID,EXE,WB; WB: RegWre=1, RegDst=1, PCWre=1, PCSrc=00; instr_cnt=1.
- lw with dmem_ack delayed 3 cycles -> mem_rd held 3+1 cycles; WB: DBDataSrc=1, RegDst=0; total 8 cycles; instr_cnt=1.
- beq with zero=1 then zero=0 -> EXE: PCSrc=01 then 00; PCWre one cycle each; 3 cycles per instruction.
- j then halt -> ID: PCSrc=10, PCWre=1; halt -> halted=1, PCWre stays 0 for 20 cycles; instr_cnt=1.
- opcode 010101 -> illegal=1, HALT; Reset=0 one cycle -> state=000, illegal=0, instr_cnt=0.
- STEP_MODE=1, step low 10 cycles -> remains IF, IRWre=0; one step pulse -> exactly one instruction retires. CNT_W=2 with 5 adds -> instr_cnt=3.
